// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Lookup is combinational. Training and flush take effect on the rising clock edge.
module branch_target_buffer #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ENTRIES     = 64,
  parameter logic [1:0]  ALLOC_STATE = 2'b10,
  parameter int unsigned PC_STEP     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PC_PREDICTED,
  output logic                  PC_PREDICTOR_STATUS,
  input  logic                  UPDATE_VALID,
  input  logic [ADDR_WIDTH-1:0] UPDATE_PC,
  input  logic [ADDR_WIDTH-1:0] UPDATE_TARGET,
  input  logic                  UPDATE_TAKEN,
  input  logic                  FLUSH
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;
  localparam logic [1:0]  CTR_INIT = 2'b01;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    logic [1:0] r;
    if (c == 2'b11) r = 2'b11;
    else            r = c + 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    logic [1:0] r;
    if (c == 2'b00) r = 2'b00;
    else            r = c - 2'b01;
    return r;
  endfunction

  logic [ENTRIES-1:0]    valid;
  logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_mem [ENTRIES];
  logic [1:0]            ctr_mem    [ENTRIES];

  logic [IDX_BITS-1:0] look_idx;
  logic [TAG_BITS-1:0] look_tag;
  logic                look_hit;
  logic                look_taken;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic                unused_bits;

  assign look_idx    = PC[IDX_BITS+1:2];
  assign look_tag    = PC[ADDR_WIDTH-1:IDX_BITS+2];
  assign upd_idx     = UPDATE_PC[IDX_BITS+1:2];
  assign upd_tag     = UPDATE_PC[ADDR_WIDTH-1:IDX_BITS+2];
  assign unused_bits = &{1'b0, PC[1:0], UPDATE_PC[1:0]};

  // Lookup: pre-edge table contents only, so a same-cycle update is never bypassed.
  always_comb begin
    look_hit   = 1'b0;
    look_taken = 1'b0;
    upd_hit    = 1'b0;
    PC_PREDICTED = PC + ADDR_WIDTH'(PC_STEP);
    if (valid[look_idx] && (tag_mem[look_idx] == look_tag)) begin
      look_hit = 1'b1;
    end else begin
      look_hit = 1'b0;
    end
    look_taken = look_hit && ctr_mem[look_idx][1];
    if (look_taken) begin
      PC_PREDICTED = target_mem[look_idx];
    end else begin
      PC_PREDICTED = PC + ADDR_WIDTH'(PC_STEP);
    end
    if (valid[upd_idx] && (tag_mem[upd_idx] == upd_tag)) begin
      upd_hit = 1'b1;
    end else begin
      upd_hit = 1'b0;
    end
  end

  assign PC_PREDICTOR_STATUS = look_taken;

  // Valid bits and direction counters: reset and flush clear them, training walks the counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        ctr_mem[i] <= CTR_INIT;
      end
    end else if (FLUSH) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        ctr_mem[i] <= CTR_INIT;
      end
    end else if (UPDATE_VALID) begin
      case ({upd_hit, UPDATE_TAKEN})
        2'b11: ctr_mem[upd_idx] <= sat_inc(ctr_mem[upd_idx]);
        2'b10: ctr_mem[upd_idx] <= sat_dec(ctr_mem[upd_idx]);
        2'b01: begin
          valid[upd_idx]   <= 1'b1;
          ctr_mem[upd_idx] <= ALLOC_STATE;
        end
        default: ctr_mem[upd_idx] <= ctr_mem[upd_idx];
      endcase
    end
  end

  // Tag and target payload: meaningless while the entry is invalid, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (!RST && !FLUSH && UPDATE_VALID && UPDATE_TAKEN) begin
      tag_mem[upd_idx]    <= upd_tag;
      target_mem[upd_idx] <= UPDATE_TARGET;
    end
  end

endmodule
